// File: rtl/ps2_key_pkg.sv
// Shared definitions for the PS/2 key controller: scancodes, action
// indices, decoder states and the scancode-to-action lookup.
`timescale 1ns/1ps
package ps2_key_pkg;

    // Prefix and mapped scancode bytes (set 2)
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LEFT   = 8'h6B;  // E0-prefixed
    localparam logic [7:0] SC_RIGHT  = 8'h74;  // E0-prefixed
    localparam logic [7:0] SC_DOWN   = 8'h72;  // E0-prefixed
    localparam logic [7:0] SC_ROTATE = 8'h75;  // E0-prefixed
    localparam logic [7:0] SC_DROP   = 8'h29;  // plain
    localparam logic [7:0] SC_HOLD   = 8'h21;  // plain

    // Bit position of each action in act_pulse / key_held
    typedef enum logic [2:0] {
        ACT_LEFT   = 3'd0,
        ACT_RIGHT  = 3'd1,
        ACT_DOWN   = 3'd2,
        ACT_ROTATE = 3'd3,
        ACT_DROP   = 3'd4,
        ACT_HOLD   = 3'd5
    } act_idx_e;

    localparam int NUM_ACT = 6;
    // Movement keys occupy the low bits, so repeaters cover bits [NUM_RPT-1:0]
    localparam int NUM_RPT = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // One-hot action for a byte; zero when the byte is not a mapped key
    // in the given (plain / extended) code space.
    function automatic logic [NUM_ACT-1:0] map_code(input logic ext, input logic [7:0] code);
        logic [NUM_ACT-1:0] hot;
        hot = '0;
        if (ext) begin
            case (code)
                SC_LEFT:   hot[ACT_LEFT]   = 1'b1;
                SC_RIGHT:  hot[ACT_RIGHT]  = 1'b1;
                SC_DOWN:   hot[ACT_DOWN]   = 1'b1;
                SC_ROTATE: hot[ACT_ROTATE] = 1'b1;
                default:   hot = '0;
            endcase
        end else begin
            case (code)
                SC_DROP: hot[ACT_DROP] = 1'b1;
                SC_HOLD: hot[ACT_HOLD] = 1'b1;
                default: hot = '0;
            endcase
        end
        return hot;
    endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// DAS/ARR auto-repeat timer for one movement key. After a press the
// counter runs DAS_CYCLES, fires, then fires every ARR_CYCLES while held.
// Releasing the key (held low) clears the timer in the same cycle.
`timescale 1ns/1ps
module ps2_repeat_timer #(
    parameter int DAS_CYCLES = 16_000_000,
    parameter int ARR_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic held,
    input  logic press,
    output logic rpt_pulse
);
    localparam int MAX_CYCLES = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_CYCLES - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_CYCLES - 1);

    logic [CW-1:0] cnt_reg;
    logic          arr_phase_reg;
    logic          rpt_pulse_reg;

    // Count while held; a fresh press restarts the delay phase
    always_ff @(posedge clk) begin
        if (rst || !held) begin
            cnt_reg       <= '0;
            arr_phase_reg <= 1'b0;
            rpt_pulse_reg <= 1'b0;
        end else if (press) begin
            cnt_reg       <= '0;
            arr_phase_reg <= 1'b0;
            rpt_pulse_reg <= 1'b0;
        end else if (cnt_reg == (arr_phase_reg ? ARR_LAST : DAS_LAST)) begin
            cnt_reg       <= '0;
            arr_phase_reg <= 1'b1;
            rpt_pulse_reg <= 1'b1;
        end else begin
            cnt_reg       <= cnt_reg + 1'b1;
            rpt_pulse_reg <= 1'b0;
        end
    end

    assign rpt_pulse = rpt_pulse_reg;

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 scancode sequencer for Tetris controls: decodes E0/F0 prefixes,
// tracks six held keys and emits one-cycle action pulses on press.
// Build macro PS2_AUTOREPEAT_EN adds DAS/ARR repeat on LEFT/RIGHT/DOWN.
`timescale 1ns/1ps
module ps2_key_controller
    import ps2_key_pkg::*;
#(
    parameter int DAS_CYCLES     = 16_000_000,
    parameter int ARR_CYCLES     = 5_000_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_valid,
    input  logic [7:0]         scan_code,
    output logic [NUM_ACT-1:0] act_pulse,
    output logic [NUM_ACT-1:0] key_held,
    output logic               seq_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    // Counter value on the cycle before it would reach TIMEOUT_CYCLES-1
    localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT_CYCLES - 2);

    dec_state_e         state_reg;
    logic [TW-1:0]      tmo_reg;
    logic [NUM_ACT-1:0] key_held_reg;
    logic [NUM_ACT-1:0] dec_pulse_reg;
    logic               seq_error_reg;

    logic               is_prefix;
    logic [NUM_ACT-1:0] code_hot;
    logic [NUM_ACT-1:0] make_hot;
    logic [NUM_ACT-1:0] brk_hot;
    logic [NUM_ACT-1:0] new_press;
    logic [NUM_ACT-1:0] held_next;
    logic [NUM_ACT-1:0] rpt_vec;

    // Classify the incoming byte as a make or break of a mapped key
    always_comb begin
        is_prefix = (scan_code == SC_EXT) || (scan_code == SC_BRK);
        code_hot  = map_code((state_reg == ST_EXT) || (state_reg == ST_EXT_BRK), scan_code);
        make_hot  = '0;
        brk_hot   = '0;
        if (scan_valid && !rst && !is_prefix) begin
            case (state_reg)
                ST_IDLE, ST_EXT:    make_hot = code_hot;
                ST_BRK, ST_EXT_BRK: brk_hot  = code_hot;
                default:            make_hot = '0;
            endcase
        end
        // Typematic repeats of an already-held key produce no new press
        new_press = make_hot & ~key_held_reg;
        held_next = rst ? '0 : ((key_held_reg | make_hot) & ~brk_hot);
    end

    // Prefix-decoder FSM with timeout and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tmo_reg       <= '0;
            key_held_reg  <= '0;
            dec_pulse_reg <= '0;
            seq_error_reg <= 1'b0;
        end else begin
            key_held_reg  <= held_next;
            dec_pulse_reg <= new_press;
            seq_error_reg <= 1'b0;
            if (scan_valid) begin
                tmo_reg <= '0;
                unique case (state_reg)
                    ST_IDLE: begin
                        if (scan_code == SC_EXT)      state_reg <= ST_EXT;
                        else if (scan_code == SC_BRK) state_reg <= ST_BRK;
                        else                          state_reg <= ST_IDLE;
                    end
                    ST_EXT: begin
                        if (scan_code == SC_BRK) begin
                            state_reg <= ST_EXT_BRK;
                        end else if (scan_code == SC_EXT) begin
                            seq_error_reg <= 1'b1;
                            state_reg     <= ST_EXT;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        if (scan_code == SC_EXT) begin
                            // A new extended sequence starts here
                            seq_error_reg <= 1'b1;
                            state_reg     <= ST_EXT;
                        end else if (scan_code == SC_BRK) begin
                            seq_error_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                endcase
            end else if (state_reg != ST_IDLE) begin
                if (tmo_reg == TMO_FIRE) begin
                    state_reg     <= ST_IDLE;
                    tmo_reg       <= '0;
                    seq_error_reg <= 1'b1;
                end else begin
                    tmo_reg <= tmo_reg + 1'b1;
                end
            end
        end
    end

`ifdef PS2_AUTOREPEAT_EN
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RPT; gi++) begin : g_rpt
            ps2_repeat_timer #(
                .DAS_CYCLES (DAS_CYCLES),
                .ARR_CYCLES (ARR_CYCLES)
            ) u_rpt (
                .clk       (clk),
                .rst       (rst),
                .held      (held_next[gi]),
                .press     (new_press[gi]),
                .rpt_pulse (rpt_vec[gi])
            );
        end
    endgenerate
    assign rpt_vec[NUM_ACT-1:NUM_RPT] = '0;
`else
    // No repeat in this build; DAS/ARR have no effect and this folds to zero
    assign rpt_vec = {NUM_ACT{(DAS_CYCLES < 0) && (ARR_CYCLES < 0)}};
`endif

    assign act_pulse = dec_pulse_reg | rpt_vec;
    assign key_held  = key_held_reg;
    assign seq_error = seq_error_reg;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed testbench for ps2_key_controller (DAS=20, ARR=5, TIMEOUT=50).
// Covers both builds of PS2_AUTOREPEAT_EN.
`timescale 1ns/1ps
module tb_ps2_key_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [5:0] act_pulse;
    logic [5:0] key_held;
    logic       seq_error;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total[6];
    int err_total = 0;
    int snap[6];
    int err_snap;

    ps2_key_controller #(
        .DAS_CYCLES     (20),
        .ARR_CYCLES     (5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .act_pulse  (act_pulse),
        .key_held   (key_held),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 6; i++) pulse_total[i] = 0;

    // Running totals of pulses seen, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) if (act_pulse[i] === 1'b1) pulse_total[i] = pulse_total[i] + 1;
        if (seq_error === 1'b1) err_total = err_total + 1;
    end

    // Advance to 1 ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle; returns with that byte's results visible
    task automatic put(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code  = b;
        cyc();
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic take_snap();
        for (int i = 0; i < 6; i++) snap[i] = pulse_total[i];
        err_snap = err_total;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        n_cmp++; if (act_pulse !== 6'b0) begin n_bad++; $display("FAIL reset_act: act_pulse=%b expected 000000", act_pulse); end
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL reset_held: key_held=%b expected 000000", key_held); end
        n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: seq_error=%b expected 0", seq_error); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_drop();
        int others;
        take_snap();
        put(8'h29);
        n_cmp++; if (act_pulse !== 6'b010000) begin n_bad++; $display("FAIL drop_pulse: act_pulse=%b expected 010000", act_pulse); end
        n_cmp++; if (key_held !== 6'b010000) begin n_bad++; $display("FAIL drop_held: key_held=%b expected 010000", key_held); end
        cyc();
        n_cmp++; if (act_pulse !== 6'b0) begin n_bad++; $display("FAIL drop_pulse_len: act_pulse=%b expected 000000", act_pulse); end
        put(8'hF0);
        put(8'h29);
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL drop_release: key_held=%b expected 000000", key_held); end
        repeat (3) cyc();
        others = 0;
        for (int i = 0; i < 6; i++) if (i != 4) others += pulse_total[i] - snap[i];
        n_cmp++; if (pulse_total[4] - snap[4] !== 1) begin n_bad++; $display("FAIL drop_count: got %0d pulses expected 1", pulse_total[4] - snap[4]); end
        n_cmp++; if (others !== 0) begin n_bad++; $display("FAIL drop_others: got %0d pulses expected 0", others); end
    endtask

    task automatic test_typematic();
        take_snap();
        put(8'hE0); put(8'h6B);
        n_cmp++; if (act_pulse !== 6'b000001) begin n_bad++; $display("FAIL left_pulse: act_pulse=%b expected 000001", act_pulse); end
        put(8'hE0); put(8'h6B);
        n_cmp++; if (act_pulse !== 6'b0) begin n_bad++; $display("FAIL left_typematic: act_pulse=%b expected 000000", act_pulse); end
        put(8'hE0); put(8'h6B);
        n_cmp++; if (key_held !== 6'b000001) begin n_bad++; $display("FAIL left_held: key_held=%b expected 000001", key_held); end
        put(8'hE0); put(8'hF0); put(8'h6B);
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL left_release: key_held=%b expected 000000", key_held); end
        repeat (3) cyc();
        n_cmp++; if (pulse_total[0] - snap[0] !== 1) begin n_bad++; $display("FAIL left_count: got %0d pulses expected 1", pulse_total[0] - snap[0]); end
    endtask

    task automatic test_autorepeat();
        logic [5:0] exp;
        take_snap();
        put(8'hE0);
        put(8'h74);  // 74 presented in cycle 0; now at +1
        n_cmp++; if (act_pulse !== 6'b000010) begin n_bad++; $display("FAIL right_press: act_pulse=%b expected 000010", act_pulse); end
        for (int t = 2; t <= 37; t++) begin
            cyc();
`ifdef PS2_AUTOREPEAT_EN
            exp = (t == 21 || t == 26 || t == 31 || t == 36) ? 6'b000010 : 6'b000000;
`else
            exp = 6'b000000;
`endif
            n_cmp++; if (act_pulse !== exp) begin n_bad++; $display("FAIL right_rpt t=%0d: act_pulse=%b expected %b", t, act_pulse, exp); end
        end
        put(8'hE0); put(8'hF0); put(8'h74);
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL right_release: key_held=%b expected 000000", key_held); end
        repeat (15) cyc();
`ifdef PS2_AUTOREPEAT_EN
        n_cmp++; if (pulse_total[1] - snap[1] !== 5) begin n_bad++; $display("FAIL right_count: got %0d pulses expected 5", pulse_total[1] - snap[1]); end
`else
        n_cmp++; if (pulse_total[1] - snap[1] !== 1) begin n_bad++; $display("FAIL right_count: got %0d pulses expected 1", pulse_total[1] - snap[1]); end
`endif
    endtask

    task automatic test_timeout();
        logic exp;
        take_snap();
        put(8'hE0);  // E0 in cycle 0; now at +1
        n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL tmo_early: seq_error=%b expected 0", seq_error); end
        for (int t = 2; t <= 60; t++) begin
            cyc();
            exp = (t == 50);
            n_cmp++; if (seq_error !== exp) begin n_bad++; $display("FAIL tmo t=%0d: seq_error=%b expected %b", t, seq_error, exp); end
        end
        put(8'h6B);
        n_cmp++; if (act_pulse !== 6'b0) begin n_bad++; $display("FAIL tmo_plain6b: act_pulse=%b expected 000000", act_pulse); end
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL tmo_held: key_held=%b expected 000000", key_held); end
        cyc();
        n_cmp++; if (err_total - err_snap !== 1) begin n_bad++; $display("FAIL tmo_count: got %0d errors expected 1", err_total - err_snap); end
    endtask

    task automatic test_resync();
        put(8'hF0);
        put(8'hE0);
        n_cmp++; if (seq_error !== 1'b1) begin n_bad++; $display("FAIL resync_err: seq_error=%b expected 1", seq_error); end
        put(8'h75);
        n_cmp++; if (act_pulse !== 6'b001000) begin n_bad++; $display("FAIL resync_rotate: act_pulse=%b expected 001000", act_pulse); end
        n_cmp++; if (seq_error !== 1'b0) begin n_bad++; $display("FAIL resync_err_clr: seq_error=%b expected 0", seq_error); end
        put(8'hE0); put(8'hF0); put(8'h75);
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL resync_release: key_held=%b expected 000000", key_held); end
    endtask

    task automatic test_back_to_back();
        put(8'h29);
        n_cmp++; if (act_pulse !== 6'b010000) begin n_bad++; $display("FAIL b2b_drop: act_pulse=%b expected 010000", act_pulse); end
        put(8'h21);
        n_cmp++; if (act_pulse !== 6'b100000) begin n_bad++; $display("FAIL b2b_hold: act_pulse=%b expected 100000", act_pulse); end
        n_cmp++; if (key_held !== 6'b110000) begin n_bad++; $display("FAIL b2b_held: key_held=%b expected 110000", key_held); end
        put(8'hF0); put(8'h29); put(8'hF0); put(8'h21);
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL b2b_release: key_held=%b expected 000000", key_held); end
    endtask

    task automatic test_reset_mid_hold();
        take_snap();
        put(8'hE0); put(8'h72);
        n_cmp++; if (act_pulse !== 6'b000100) begin n_bad++; $display("FAIL down_press: act_pulse=%b expected 000100", act_pulse); end
        n_cmp++; if (key_held !== 6'b000100) begin n_bad++; $display("FAIL down_held: key_held=%b expected 000100", key_held); end
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL rst_held: key_held=%b expected 000000", key_held); end
        put(8'hE0); put(8'h72);
        n_cmp++; if (act_pulse !== 6'b0) begin n_bad++; $display("FAIL rst_pulse: act_pulse=%b expected 000000", act_pulse); end
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL rst_ignore: key_held=%b expected 000000", key_held); end
        rst = 1'b0;
        cyc();
        put(8'h72);
        n_cmp++; if (act_pulse !== 6'b0) begin n_bad++; $display("FAIL post_rst_72: act_pulse=%b expected 000000", act_pulse); end
        n_cmp++; if (key_held !== 6'b0) begin n_bad++; $display("FAIL post_rst_held: key_held=%b expected 000000", key_held); end
        repeat (30) cyc();
        n_cmp++; if (pulse_total[2] - snap[2] !== 1) begin n_bad++; $display("FAIL down_count: got %0d pulses expected 1", pulse_total[2] - snap[2]); end
    endtask

    initial begin
        test_reset();
        test_drop();
        test_typematic();
        test_autorepeat();
        test_timeout();
        test_resync();
        test_back_to_back();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
